comp_decomp_engine: RTL

- Dictionary-based compression/decompression engine: the DUT-side end of the comp_if command/response interface.
- COMPRESS maps a DATA_WIDTH symbol to a dictionary index. A miss inserts the symbol as a new entry.
- DECOMPRESS maps an index back to its symbol. CLEAR empties the dictionary.
- Sits behind the comp_if driver/monitor bench and is the RTL counterpart checked against the SystemC reference model.

---
 rtl/comp_pkg.sv | 9 +
 rtl/comp_dict_mem.sv | 28 ++
 rtl/comp_decomp_engine.sv | 92 +++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// comp_pkg: shared command, response and state encodings for the dictionary engine
package comp_pkg;
  typedef enum logic [1:0] {CMD_NOP, CMD_COMPRESS, CMD_DECOMPRESS, CMD_CLEAR} cmd_e;
  typedef enum logic [1:0] {RSP_NONE, RSP_OK_HIT, RSP_ERROR, RSP_OK_NEW} rsp_e;
  typedef enum logic {S_IDLE, S_SEARCH} state_e;
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/comp_dict_mem.sv
// comp_dict_mem: append-only symbol store with fill count, one search and one lookup read port
module comp_dict_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clr,
  input  logic [IDX_W-1:0]      sidx,
  output logic [DATA_WIDTH-1:0] sdata,
  input  logic [IDX_W-1:0]      didx,
  output logic [DATA_WIDTH-1:0] ddata,
  output logic [IDX_W:0]        count
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  assign sdata = mem[sidx];
  assign ddata = mem[didx];
  // writes always append at the current fill level
  always_ff @(posedge clk)
    if (we) mem[count[IDX_W-1:0]] <= wdata;
  // fill count; each write appends exactly one entry
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (we) count <= count + 1'b1;
endmodule

// File: rtl/comp_decomp_engine.sv
// comp_decomp_engine: dictionary compressor with linear search and indexed decompress
module comp_decomp_engine
  import comp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] compressed_in,
  input  logic [1:0]            command,
  output logic [DATA_WIDTH-1:0] compressed_out,
  output logic [DATA_WIDTH-1:0] decompressed_out,
  output logic [1:0]            response,
  output logic                  busy
);
  localparam int IDX_W = idx_w(DEPTH);
  state_e state, state_n;
  rsp_e rsp_n;
  cmd_e cmd;
  logic [IDX_W-1:0] idx, idx_n;
  logic [IDX_W:0] count;
  logic [DATA_WIDTH-1:0] sym, sym_n, cout_n, dout_n, sdata, ddata;
  logic busy_n, we, clr, hit, last, full, dvalid;
  assign cmd = cmd_e'(command);
  comp_dict_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk(clk), .rst(rst), .we(we), .wdata(sym), .clr(clr),
    .sidx(idx), .sdata(sdata), .didx(compressed_in[IDX_W-1:0]), .ddata(ddata), .count(count)
  );
  // next-state, datapath and response decode; stale entries beyond count never match
  always_comb begin
    hit = ({1'b0, idx} < count) && (sdata == sym);
    last = (count == '0) || ({1'b0, idx} + 1'b1 == count);
    full = count == (IDX_W+1)'(DEPTH);
    dvalid = (DATA_WIDTH+1)'(compressed_in) < (DATA_WIDTH+1)'(count);
    state_n = state;
    idx_n = idx;
    sym_n = sym;
    rsp_n = RSP_NONE;
    cout_n = compressed_out;
    dout_n = decompressed_out;
    busy_n = 1'b0;
    we = 1'b0;
    clr = 1'b0;
    if (state == S_IDLE) begin
      if (cmd == CMD_COMPRESS) begin
        sym_n = data_in;
        idx_n = '0;
        state_n = S_SEARCH;
        busy_n = 1'b1;
      end else if (cmd == CMD_DECOMPRESS) begin
        rsp_n = dvalid ? RSP_OK_HIT : RSP_ERROR;
        dout_n = dvalid ? ddata : decompressed_out;
      end else if (cmd == CMD_CLEAR) begin
        clr = 1'b1;
        rsp_n = RSP_OK_HIT;
      end
    end else if (hit) begin
      rsp_n = RSP_OK_HIT;
      cout_n = DATA_WIDTH'(idx);
      state_n = S_IDLE;
    end else if (last) begin
      rsp_n = full ? RSP_ERROR : RSP_OK_NEW;
      cout_n = full ? compressed_out : DATA_WIDTH'(count);
      we = !full;
      state_n = S_IDLE;
    end else begin
      idx_n = idx + 1'b1;
      busy_n = 1'b1;
    end
  end
  // state, capture and output registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      sym <= '0;
      response <= RSP_NONE;
      compressed_out <= '0;
      decompressed_out <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      sym <= sym_n;
      response <= rsp_n;
      compressed_out <= cout_n;
      decompressed_out <= dout_n;
      busy <= busy_n;
    end
endmodule
